// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one byte-wide UART transmitter among N_REQ requesters.
// Optional idle-owner grant revocation is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int OW = $clog2(N_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [8*N_REQ-1:0] i_req_data,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [N_REQ-1:0]   i_req_last,
   output logic [N_REQ-1:0]   o_req_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic [OW-1:0]      o_owner,
   output logic               o_timeout
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [OW-1:0] owner_q, owner_d, last_q, last_d, winner, idx;
   logic active, own_valid, own_last, hs, revoke;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
   end

   // Gating with reset keeps the handshake dead during a reset cycle taken mid-packet.
   assign active    = state_q == BUSY && !i_rst;
   assign own_valid = i_req_valid[owner_q];
   assign own_last  = i_req_last[owner_q];
   assign hs        = active && own_valid && i_tx_ready;

   assign o_busy      = active;
   assign o_owner     = owner_q;
   assign o_tx_valid  = active && own_valid;
   assign o_tx_data   = i_req_data[{owner_q, 3'b000} +: 8];
   assign o_req_ready = (active && i_tx_ready) ? N_REQ'(1) << owner_q : '0;

   // Scan from the far end so the requester nearest last_q+1 is written last and wins.
   always_comb begin
      winner = '0;
      idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = OW'((int'(last_q) + i) % N_REQ);
         if (i_req_valid[idx]) winner = idx;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] cnt_q, cnt_d;
   assign revoke    = active && !own_valid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   assign cnt_d     = (!active || own_valid || revoke) ? '0 : cnt_q + 1'b1;
   assign o_timeout = revoke;
   always_ff @(posedge i_clk) begin
      cnt_q <= i_rst ? '0 : cnt_d;
   end
`else
   assign revoke    = 1'b0;
   assign o_timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      if (state_q == IDLE && |i_req_valid) begin
         state_d = BUSY;
         owner_d = winner;
      end else if (state_q == BUSY && ((hs && own_last) || revoke)) begin
         state_d = IDLE;
         last_d  = owner_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= OW'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter; expected serial bytes are queued at stimulus time.
// Timeout expectations follow UART_ARB_TIMEOUT_EN, with TIMEOUT_CYCLES=8.
module tb_uart_tx_arbiter;
   localparam int N = 4;
   logic clk = 1'b0, rst = 1'b1, tx_ready = 1'b1;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [7:0] tx_data;
   logic tx_valid, busy, tmo;
   logic [1:0] owner;
   int checks = 0, failures = 0, cyc = 0, stall = 0, to_cnt = 0, to_at = -1, rel = 0, n_hs = 0;
   logic [8:0] src[N][$];
   logic [9:0] exp_q[$];
   int hs_cyc[$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_data(req_data), .i_req_valid(req_valid),
      .i_req_last(req_last), .o_req_ready(req_ready), .o_tx_data(tx_data),
      .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_busy(busy), .o_owner(owner),
      .o_timeout(tmo)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic push(int k, logic [7:0] d, logic l);
      src[k].push_back({l, d});
      exp_q.push_back({2'(k), d});
   endtask

   task automatic drain(string nm, int max);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk({nm, "_outstanding"}, exp_q.size(), 0);
   endtask

   // Requester models present the head of their queue just after each clock edge.
   initial forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         req_valid[k] = src[k].size() != 0;
         if (req_valid[k]) {req_last[k], req_data[k*8 +: 8]} = src[k][0];
         else {req_last[k], req_data[k*8 +: 8]} = 9'h0;
      end
   end

   // Monitor: every handshake is compared against the scoreboard head.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         chk("rst_tx_valid", tx_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_timeout", tmo, 0);
      end
      if (busy) begin
         chk("ready_only_owner", req_ready & ~(4'b1 << owner), 0);
         if (!tx_valid) stall++;
      end
      if (tmo) begin
         to_cnt++;
         to_at = stall;
      end
      if (tx_valid && tx_ready) begin
         hs_cyc.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte: got owner %0d byte %0h required none", owner, tx_data);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if ({owner, tx_data} !== e) begin
               failures++;
               $display("FAIL tx_byte: got owner %0d byte %0h required owner %0d byte %0h",
                        owner, tx_data, e[9:8], e[7:0]);
            end
         end
      end
      for (int k = 0; k < N; k++)
         if (req_valid[k] && req_ready[k] && src[k].size() != 0) void'(src[k].pop_front());
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with everyone pending, then two rounds of single-byte packets
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N; k++) push(k, 8'h30 + 8'(k), 1'b1);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      rel = cyc;
      drain("round_robin", 60);
      chk("rr_handshakes", hs_cyc.size(), 8);
      if (hs_cyc.size() != 0) chk("first_grant_latency", hs_cyc[0] - rel, 2);
      for (int i = 1; i < hs_cyc.size(); i++) chk("rr_gap", hs_cyc[i] - hs_cyc[i-1], 2);

      // Packet lock: requester 2 waits behind requester 1's three-byte packet
      push(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b0);
      push(1, 8'h43, 1'b1);
      push(2, 8'h5A, 1'b1);
      drain("packet_lock", 50);

      // Backpressure on the transmitter
      tx_ready = 1'b0;
      push(2, 8'h61, 1'b0);
      push(2, 8'h62, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      n_hs = hs_cyc.size();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_data", tx_data, 8'h61);
         chk("bp_owner", owner, 2);
         chk("bp_valid", tx_valid, 1);
      end
      chk("bp_no_handshake", hs_cyc.size(), n_hs);
      tx_ready = 1'b1;
      drain("backpressure", 20);

      // Owner 0 stalls after one byte while requester 1 waits
      stall = 0;
      to_cnt = 0;
      push(0, 8'h10, 1'b0);
      src[1].push_back({1'b1, 8'h20});
`ifdef UART_ARB_TIMEOUT_EN
      exp_q.push_back({2'd1, 8'h20});
      drain("timeout_regrant", 60);
      chk("timeout_pulses", to_cnt, 1);
      chk("timeout_invalid_cycles", to_at, 8);
`else
      repeat (110) @(posedge clk);
      #2;
      chk("stall_busy", busy, 1);
      chk("stall_owner", owner, 0);
      chk("stall_ge_100", stall >= 100, 1);
      chk("no_timeout", to_cnt, 0);
      push(0, 8'h11, 1'b1);
      exp_q.push_back({2'd1, 8'h20});
      drain("stall_release", 30);
`endif

      // Reset after byte 2 of 4 from owner 3
      push(3, 8'h71, 1'b0);
      push(3, 8'h72, 1'b0);
      src[3].push_back({1'b0, 8'h73});
      src[3].push_back({1'b1, 8'h74});
      drain("mid_first_two", 30);
      rst = 1'b1;
      push(0, 8'h01, 1'b1);
      exp_q.push_back({2'd3, 8'h73});
      exp_q.push_back({2'd3, 8'h74});
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", busy, 0);
      chk("post_reset_owner", owner, 0);
      drain("reset_rearb", 40);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one byte-wide UART transmitter between `N_REQ` byte-stream requesters, such as the CPU MMIO console, a debug monitor and a trace unit. A requester is granted for a whole packet, delimited by `i_req_last`, so messages from different sources never interleave on the serial line. The block sits between the requesters and the transmitter's `i_data`/`i_valid`/`o_ready` port.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 65535: idle-owner timeout in clocks, ≥ 2. Used only with `UART_ARB_TIMEOUT_EN`.
- Clock `i_clk`; reset `i_rst`, synchronous, active-high.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_req_data`  in  8*N_REQ  byte from requester k at bits [8k+7:8k].
- `i_req_valid`  in  N_REQ  requester k has a byte.
- `i_req_last`  in  N_REQ  byte from requester k ends its packet.
- `o_req_ready`  out  N_REQ  byte from requester k accepted this cycle when valid and ready are both high.
- `o_tx_data`  out  8  byte to the transmitter.
- `o_tx_valid`  out  1  byte valid to the transmitter.
- `i_tx_ready`  in  1  transmitter ready.
- `o_busy`  out  1  a packet is in progress (state BUSY).
- `o_owner`  out  $clog2(N_REQ)  current or last owner index.
- `o_timeout`  out  1  one-cycle pulse when a grant is revoked. Constant 0 without the macro.

## Operation
- FSM states are IDLE and BUSY. State, `owner` and the round-robin pointer `last` are registers.
- Reset values: state IDLE, `owner` 0, `last` N_REQ-1 (so requester 0 wins first), timeout counter 0.
- Reset output values: `o_busy` 0, `o_tx_valid` 0, `o_req_ready` all 0, `o_timeout` 0, `o_owner` 0. `o_tx_data` is don't-care.
- **IDLE:**
  - `o_tx_valid` is 0 and `o_req_ready` is all 0.
  - If any `i_req_valid` bit is set, the winner is the first set bit scanning `last`+1, `last`+2, … modulo N_REQ.
  - `owner` ← winner, then go to BUSY.
- **BUSY:**
  - `o_tx_data` = byte of `owner`; `o_tx_valid` = `i_req_valid[owner]`.
  - `o_req_ready[owner]` = `i_tx_ready`; all other ready bits are 0. These paths are combinational.
  - A handshake occurs when `i_req_valid[owner]` & `i_tx_ready`.
  - A handshake with `i_req_last[owner]` set returns the FSM to IDLE and sets `last` ← `owner`.
  - Requests from non-owners are ignored. They must hold their valid until granted.
- Only the selected requester's data, valid and last bits are sampled. Other requesters' inputs never affect `o_tx_*`.
- Reset asserted mid-packet forces IDLE next cycle with no handshake that cycle; the partial packet is abandoned.

## Timing
- Grant latency:
  - A request is first seen in IDLE at cycle t.
  - BUSY starts at t+1, and `o_tx_valid` can be high at t+1.
  - The first handshake is possible at t+1.
- Back-to-back packets:
  - A last-byte handshake at cycle t gives IDLE at t+1 and a new grant at t+2.
  - This leaves one dead cycle per packet boundary. It is negligible against the byte time.
- Throughput is limited only by `i_tx_ready`. Single-byte packets (last set on byte 1) are legal.
- `owner` and `last` never change while in BUSY. `o_owner` holds its value through IDLE until the next grant.
- The arbiter inserts no combinational path from `i_tx_ready` to `o_tx_valid`.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - In BUSY, a counter increments on every cycle where `i_req_valid[owner]` is 0. It clears on any cycle where the owner is valid, and on entry to BUSY.
  - When the counter reaches TIMEOUT_CYCLES-1 with the owner still invalid, the grant is revoked. The FSM goes to IDLE, `last` ← `owner`, and `o_timeout` pulses for one cycle.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- **Undefined:** no counter is built, `o_timeout` is tied to 0, and a stalled owner holds the grant indefinitely.

## Test plan
- **Reset defaults:** hold `i_rst` for 3 cycles with all `i_req_valid` high -> `o_tx_valid`=0, `o_req_ready`=0, `o_busy`=0; after release, the first grant goes to owner 0.
- **Packet lock:** requester 1 sends 0x41,0x42,0x43 (last on 0x43) while requester 2 holds 0x5A valid -> the serial byte order is 41,42,43,5A; `o_req_ready[2]` is 0 until the cycle after 0x43 plus one.
- **Round robin:** all 4 requesters continuously send single-byte packets 0x30+k -> grant order 0,1,2,3,0,… with exactly one IDLE cycle between handshakes when `i_tx_ready` is tied high.
- **Backpressure:** `i_tx_ready` low for 20 cycles during a packet -> `o_tx_data` is stable at the owner's byte, no handshake occurs, and the owner is unchanged.
- **Timeout (macro defined, TIMEOUT_CYCLES=8):** owner 0 sends 0x10 without last, then drops valid -> after 8 invalid cycles `o_timeout` pulses once and requester 1 is granted; without the macro, owner 0 stays granted for ≥ 100 cycles.
- **Reset mid-packet:** pulse `i_rst` after byte 2 of 4 from owner 3 -> IDLE next cycle and no handshake in the reset cycle; requester 0 wins the next arbitration.
